memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// Pipeline stage between execute and writeback. Issues data-memory loads/stores over a ready-handshake bus.
// Aligns and extends load data, generates store byte enables, and raises misaligned-access exceptions.
// Stalls the front end while an access is outstanding. All writeback-bound signals are in an output register.
// PARAMETERS
// none (XLEN fixed at 32; load_store_size 00=byte 01=half 10=word, 11 treated as word)
// PORTS
// clk                 in   1   clock, all state on rising edge
// reset               in   1   asynchronous, active-high
// pc_in,next_pc_in    in   32  from execute
// alu_data_in         in   32  ALU result; also the load/store address
// store_data_in       in   32  rs2 value for stores
// csr_data_in         in   32  pass-through
// load_in,store_in    in   1   access type, mutually exclusive
// load_store_size_in  in   2   access size
// load_signed_in      in   1   sign-extend loads
// write_select_in     in   2   pass-through
// rd_address_in       in   5   pass-through
// csr_address_in      in   12  pass-through
// mret_in,wfi_in      in   1   pass-through
// valid_in            in   1   instruction present
// exception_in        in   1   earlier exception
// ecause_in           in   4   earlier exception cause
// flush               in   1   trap taken in writeback; kill current op
// stall               out  1   hold execute and earlier stages
// mem_address         out  32  word-aligned address {alu_data_in[31:2],2'b00}
// mem_store_data      out  32  replicated store data
// mem_byte_enable     out  4   store lane mask
// mem_read,mem_write  out  1   request strobes
// mem_ready           in   1   access complete this cycle
// mem_load_data       in   32  valid when mem_ready
// *_out               out  -   registered copies of all pass-through inputs, widths as inputs
// load_data_out       out  32  aligned/extended load result
// valid_out,exception_out out 1; ecause_out out 4
// BEHAVIOUR
// - Reset: state=IDLE; every *_out, load_data_out, valid_out, exception_out = 0.
// - Strobes/address/byte enables are combinational from the inputs; stall=req && !mem_ready.
// - mem_read/mem_write are 0 when no request.
// - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
// - Misaligned access raises exception_out=1 with ecause 4 (load) or 6 (store).
// - A misaligned access issues no bus request.
// - An earlier exception_in takes priority and passes through unchanged.
// - req = valid_in && !exception_in && (load_in||store_in) && aligned && !(flush && state==IDLE).
// - FSM IDLE: req && !mem_ready -> WAIT; req && mem_ready -> stays IDLE (single-cycle access).
// - FSM WAIT: hold request, addresses and strobes; mem_ready -> IDLE.
// - WAIT: flush is recorded in a sticky kill bit; bus access still completes (no retraction).
// - WAIT: when the access completes, the result is captured with valid_out=0.
// - Output register loads when !stall.
// - While stalled, it loads a bubble: valid_out=0 and exception_out=0, so writeback never retires twice.
// - Captured valid_out = valid_in && !flush && !kill; kill clears on capture.
// - Byte enables: byte 4'b0001<<a, half 4'b0011<<a, word 4'b1111, where a=addr[1:0].
// - Store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
// - Byte enables and store data are driven only when mem_write=1, else 0.
// - Load: shift mem_load_data right by a*8, then take size bits.
// - Load: sign-extend if load_signed_in, else zero-extend; non-loads give load_data_out=0.
// - Reset mid-access: immediate return to IDLE; strobes drop; kill and outputs clear.
// TESTING
// - lw addr 0x100, mem_ready same cycle, data 0xDEADBEEF -> no stall; next cycle load_data_out=0xDEADBEEF, valid_out=1.
// - lb signed addr 0x103, data 0x80FFFFFF -> byte_enable 0 (read); load_data_out=0xFFFFFF80.
// - lb unsigned, same data -> load_data_out=0x00000080.
// - sh addr 0x102, data 0x0000ABCD, mem_ready after 3 cycles -> stall=1 for 3 cycles.
// - Same sh -> mem_byte_enable=4'b1100, mem_store_data=0xABCDABCD; bubbles out, then valid_out=1.
// - lw addr 0x101 -> mem_read=0, exception_out=1, ecause_out=4.
// - sw addr 0x102 -> exception_out=1, ecause_out=6.
// - Load in WAIT, flush pulses, mem_ready 2 cycles later -> mem_read held until ready; valid_out=0 after capture.
// - Reset asserted during WAIT -> all outputs 0 and mem_read=0 immediately; next lw after reset completes normally.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
//   mem_address     : word-aligned access address
//   mem_store_data  : store data replicated across the byte lanes
//   mem_byte_enable : store lane mask
//   mem_read        : load request strobe
//   mem_write       : store request strobe
//   mem_ready       : access completes this cycle
//   mem_load_data   : load data, valid while mem_ready is high
interface memory_stage_if;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;
  logic [31:0] mem_load_data;

  modport master (
    output mem_address, mem_store_data, mem_byte_enable, mem_read, mem_write,
    input  mem_ready, mem_load_data
  );

  modport slave (
    input  mem_address, mem_store_data, mem_byte_enable, mem_read, mem_write,
    output mem_ready, mem_load_data
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline stage between execute and writeback.
// Issues data-memory loads and stores over a ready-handshake bus. It aligns and
// extends load data, generates store byte enables and raises misaligned-access
// exceptions. While an access is outstanding, the stage stalls the front end.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   *_in                : instruction fields from execute
//   flush               : trap taken in writeback, kill the current op
//   stall               : hold execute and earlier stages
//   mem_bus             : data-memory bus (master side)
//   *_out               : registered writeback-bound fields
//   load_data_out       : aligned and extended load result
//   valid_out, exception_out, ecause_out : registered status
module memory_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] csr_data_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  load_store_size_in,
  input  logic        load_signed_in,
  input  logic [1:0]  write_select_in,
  input  logic [4:0]  rd_address_in,
  input  logic [11:0] csr_address_in,
  input  logic        mret_in,
  input  logic        wfi_in,
  input  logic        valid_in,
  input  logic        exception_in,
  input  logic [3:0]  ecause_in,
  input  logic        flush,
  output logic        stall,
  memory_stage_if.master mem_bus,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] csr_data_out,
  output logic [1:0]  write_select_out,
  output logic [4:0]  rd_address_out,
  output logic [11:0] csr_address_out,
  output logic        mret_out,
  output logic        wfi_out,
  output logic [31:0] load_data_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

  state_t      state_q, state_d;
  logic        kill_q;
  logic [1:0]  byte_off;
  logic        mem_op;
  logic        aligned;
  logic        misaligned;
  logic        req;
  logic        exc_d;
  logic [3:0]  ecause_d;
  logic [31:0] load_data_d;
  logic        vld_d;

  // Sign- or zero-extend the low size bits of already right-shifted load data.
  function automatic logic [31:0] extend_load(input logic [31:0] shifted,
                                              input logic [1:0]  size,
                                              input logic        sign_ext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = signed'(shifted[7:0]);
    h = signed'(shifted[15:0]);
    case (size)
      2'b00:   r = sign_ext ? 32'(b) : {24'd0, shifted[7:0]};
      2'b01:   r = sign_ext ? 32'(h) : {16'd0, shifted[15:0]};
      default: r = signed'(shifted);
    endcase
    return unsigned'(r);
  endfunction

  always_comb begin
    byte_off = alu_data_in[1:0];
    mem_op   = load_in || store_in;
    case (load_store_size_in)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !byte_off[0];
      default: aligned = (byte_off == 2'b00);
    endcase
    misaligned = valid_in && !exception_in && mem_op && !aligned;
    // A flush in WAIT does not retract the request: the bus access must finish.
    // The reset term drops the strobes at once when reset arrives mid-access.
    req   = !reset && valid_in && !exception_in && mem_op && aligned &&
            !(flush && state_q == IDLE);
    stall = req && !mem_bus.mem_ready;
  end

  always_comb begin
    mem_bus.mem_address     = {alu_data_in[31:2], 2'b00};
    mem_bus.mem_read        = req && load_in;
    mem_bus.mem_write       = req && store_in;
    mem_bus.mem_byte_enable = 4'b0000;
    mem_bus.mem_store_data  = 32'd0;
    if (mem_bus.mem_write) begin
      case (load_store_size_in)
        2'b00: begin
          mem_bus.mem_byte_enable = 4'b0001 << byte_off;
          mem_bus.mem_store_data  = {4{store_data_in[7:0]}};
        end
        2'b01: begin
          mem_bus.mem_byte_enable = 4'b0011 << byte_off;
          mem_bus.mem_store_data  = {2{store_data_in[15:0]}};
        end
        default: begin
          mem_bus.mem_byte_enable = 4'b1111;
          mem_bus.mem_store_data  = store_data_in;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req && !mem_bus.mem_ready) state_d = WAIT;
      WAIT: if (mem_bus.mem_ready || !req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A flush seen while waiting is remembered until the access is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          kill_q <= 1'b0;
    else if (!stall)                    kill_q <= 1'b0;
    else if (flush && state_q == WAIT)  kill_q <= 1'b1;
  end

  always_comb begin
    exc_d = exception_in || misaligned;
    if (exception_in)    ecause_d = ecause_in;
    else if (misaligned) ecause_d = load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED;
    else                 ecause_d = 4'd0;
    load_data_d = load_in ?
      extend_load(mem_bus.mem_load_data >> {byte_off, 3'b000}, load_store_size_in, load_signed_in) :
      32'd0;
    vld_d = valid_in && !flush && !kill_q;
  end

  // ---- output register (writeback boundary) ----
  // Loads every cycle; while stalled it takes a bubble so one op retires once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out           <= 32'd0;
      next_pc_out      <= 32'd0;
      alu_data_out     <= 32'd0;
      csr_data_out     <= 32'd0;
      write_select_out <= 2'd0;
      rd_address_out   <= 5'd0;
      csr_address_out  <= 12'd0;
      mret_out         <= 1'b0;
      wfi_out          <= 1'b0;
      load_data_out    <= 32'd0;
      valid_out        <= 1'b0;
      exception_out    <= 1'b0;
      ecause_out       <= 4'd0;
    end else begin
      pc_out           <= pc_in;
      next_pc_out      <= next_pc_in;
      alu_data_out     <= alu_data_in;
      csr_data_out     <= csr_data_in;
      write_select_out <= write_select_in;
      rd_address_out   <= rd_address_in;
      csr_address_out  <= csr_address_in;
      mret_out         <= mret_in;
      wfi_out          <= wfi_in;
      load_data_out    <= load_data_d;
      valid_out        <= stall ? 1'b0 : vld_d;
      exception_out    <= stall ? 1'b0 : exc_d;
      ecause_out       <= ecause_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, next_pc_in, alu_data_in, store_data_in, csr_data_in;
  logic        load_in, store_in, load_signed_in, mret_in, wfi_in;
  logic [1:0]  load_store_size_in, write_select_in;
  logic [4:0]  rd_address_in;
  logic [11:0] csr_address_in;
  logic        valid_in, exception_in, flush;
  logic [3:0]  ecause_in;
  logic        stall;
  logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out;
  logic [1:0]  write_select_out;
  logic [4:0]  rd_address_out;
  logic [11:0] csr_address_out;
  logic        mret_out, wfi_out, valid_out, exception_out;
  logic [3:0]  ecause_out;

  memory_stage_if bus ();

  memory_stage dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .next_pc_in(next_pc_in), .alu_data_in(alu_data_in),
    .store_data_in(store_data_in), .csr_data_in(csr_data_in),
    .load_in(load_in), .store_in(store_in), .load_store_size_in(load_store_size_in),
    .load_signed_in(load_signed_in), .write_select_in(write_select_in),
    .rd_address_in(rd_address_in), .csr_address_in(csr_address_in),
    .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in),
    .exception_in(exception_in), .ecause_in(ecause_in), .flush(flush),
    .stall(stall), .mem_bus(bus.master),
    .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
    .csr_data_out(csr_data_out), .write_select_out(write_select_out),
    .rd_address_out(rd_address_out), .csr_address_out(csr_address_out),
    .mret_out(mret_out), .wfi_out(wfi_out), .load_data_out(load_data_out),
    .valid_out(valid_out), .exception_out(exception_out), .ecause_out(ecause_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        exc;
    logic [3:0]  ecause;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_ctr   = 32'h0000_1000;
  logic [4:0]  rd_ctr   = 5'd1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every retired op must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (valid_out || exception_out)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_retire: got pc %h with empty queue, expected none", pc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_pc",        pc_out,                 e.pc);
        check("mon_rd",        {27'd0, rd_address_out}, {27'd0, e.rd});
        check("mon_valid",     {31'd0, valid_out},     32'd1);
        check("mon_exception", {31'd0, exception_out}, {31'd0, e.exc});
        check("mon_ecause",    {28'd0, ecause_out},    {28'd0, e.ecause});
        check("mon_load_data", load_data_out,          e.ld);
      end
    end
  end

  task automatic clear_inputs();
    valid_in = 0; load_in = 0; store_in = 0; load_signed_in = 0;
    load_store_size_in = 2'b00; alu_data_in = 0; store_data_in = 0;
    flush = 0; exception_in = 0; ecause_in = 0;
    bus.mem_ready = 0; bus.mem_load_data = 0;
  endtask

  task automatic set_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] sdata);
    pc_in = pc_ctr; next_pc_in = pc_ctr + 4; rd_address_in = rd_ctr;
    csr_data_in = 32'h5A5A_0000 | pc_ctr; csr_address_in = 12'h300;
    write_select_in = 2'b01;
    load_in = ld; store_in = st; load_store_size_in = sz; load_signed_in = sgn;
    alu_data_in = addr; store_data_in = sdata; valid_in = 1;
  endtask

  // Called at posedge+1. Holds the op for dly stalled cycles, then completes it.
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int dly,
                        input logic exp_rd, input logic exp_wr, input logic [3:0] exp_be,
                        input logic [31:0] exp_sd, input logic exp_exc, input logic [3:0] exp_ec,
                        input logic [31:0] exp_ld);
    exp_t e;
    set_op(ld, st, sz, sgn, addr, sdata);
    e.pc = pc_ctr; e.rd = rd_ctr; e.exc = exp_exc; e.ecause = exp_ec; e.ld = exp_ld;
    sb.push_back(e);
    for (int c = 0; c <= dly; c++) begin
      bus.mem_ready     = (c == dly);
      bus.mem_load_data = (c == dly) ? rdata : 32'd0;
      #1;
      check({nm, "_stall"},   {31'd0, stall},         {31'd0, (c < dly)});
      check({nm, "_read"},    {31'd0, bus.mem_read},  {31'd0, exp_rd});
      check({nm, "_write"},   {31'd0, bus.mem_write}, {31'd0, exp_wr});
      check({nm, "_be"},      {28'd0, bus.mem_byte_enable}, {28'd0, exp_be});
      check({nm, "_sdata"},   bus.mem_store_data,     exp_sd);
      check({nm, "_address"}, bus.mem_address,        {addr[31:2], 2'b00});
      @(posedge clk); #1;
    end
    clear_inputs();
    pc_ctr = pc_ctr + 4;
    rd_ctr = rd_ctr + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    pc_in = 0; next_pc_in = 0; csr_data_in = 0; rd_address_in = 0;
    csr_address_in = 0; write_select_in = 0; mret_in = 0; wfi_in = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",     {31'd0, valid_out},     32'd0);
    check("rst_exception", {31'd0, exception_out}, 32'd0);
    check("rst_load_data", load_data_out,          32'd0);
    check("rst_pc",        pc_out,                 32'd0);
    check("rst_stall",     {31'd0, stall},         32'd0);
    check("rst_read",      {31'd0, bus.mem_read},  32'd0);
    reset = 0;
    @(posedge clk); #1;

    // lw 0x100, same-cycle ready
    run_op("lw", 1, 0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0,
           1, 0, 4'b0000, 0, 0, 4'd0, 32'hDEADBEEF);
    // lb signed / unsigned at 0x103
    run_op("lb_s", 1, 0, 2'b00, 1, 32'h103, 0, 32'h80FFFFFF, 0,
           1, 0, 4'b0000, 0, 0, 4'd0, 32'hFFFFFF80);
    run_op("lb_u", 1, 0, 2'b00, 0, 32'h103, 0, 32'h80FFFFFF, 0,
           1, 0, 4'b0000, 0, 0, 4'd0, 32'h00000080);
    // lh signed at 0x102 with 1 wait cycle
    run_op("lh_s", 1, 0, 2'b01, 1, 32'h102, 0, 32'h9234_5678, 1,
           1, 0, 4'b0000, 0, 0, 4'd0, 32'hFFFF9234);
    // sh 0x102, ready after 3 stalled cycles
    run_op("sh", 0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 0, 3,
           0, 1, 4'b1100, 32'hABCDABCD, 0, 4'd0, 32'd0);
    // sb 0x101
    run_op("sb", 0, 1, 2'b00, 0, 32'h101, 32'h0000_00C3, 0, 0,
           0, 1, 4'b0010, 32'hC3C3C3C3, 0, 4'd0, 32'd0);
    // misaligned lw / sw
    run_op("lw_mis", 1, 0, 2'b10, 0, 32'h101, 0, 0, 0,
           0, 0, 4'b0000, 0, 1, 4'd4, 32'd0);
    run_op("sw_mis", 0, 1, 2'b10, 0, 32'h102, 32'h1111_2222, 0, 0,
           0, 0, 4'b0000, 0, 1, 4'd6, 32'd0);
    // earlier exception passes through, no bus request
    exception_in = 1; ecause_in = 4'd2;
    run_op("exc_in", 1, 0, 2'b10, 0, 32'h101, 0, 0, 0,
           0, 0, 4'b0000, 0, 1, 4'd2, 32'd0);

    // load in WAIT, flush pulses, ready two cycles after the flush
    set_op(1, 0, 2'b10, 0, 32'h200, 0);
    #1;
    check("fl_stall0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    flush = 1;
    #1;
    check("fl_read1",  {31'd0, bus.mem_read}, 32'd1);
    check("fl_stall1", {31'd0, stall},        32'd1);
    @(posedge clk); #1;
    flush = 0;
    #1;
    check("fl_read2",  {31'd0, bus.mem_read}, 32'd1);
    @(posedge clk); #1;
    bus.mem_ready = 1; bus.mem_load_data = 32'h1234_5678;
    #1;
    check("fl_read3",  {31'd0, bus.mem_read}, 32'd1);
    check("fl_stall3", {31'd0, stall},        32'd0);
    @(posedge clk); #1;
    clear_inputs();
    check("fl_valid_out", {31'd0, valid_out}, 32'd0);
    check("fl_load_data", load_data_out,      32'h1234_5678);
    pc_ctr = pc_ctr + 4; rd_ctr = rd_ctr + 1;

    // flush while idle suppresses the request
    set_op(1, 0, 2'b10, 0, 32'h204, 0);
    flush = 1;
    #1;
    check("fli_read",  {31'd0, bus.mem_read}, 32'd0);
    check("fli_stall", {31'd0, stall},        32'd0);
    @(posedge clk); #1;
    clear_inputs();
    check("fli_valid_out", {31'd0, valid_out}, 32'd0);
    pc_ctr = pc_ctr + 4; rd_ctr = rd_ctr + 1;

    // reset during WAIT
    set_op(1, 0, 2'b10, 0, 32'h300, 0);
    @(posedge clk); #1;
    check("rw_stall", {31'd0, stall}, 32'd1);
    reset = 1;
    #1;
    check("rw_read",  {31'd0, bus.mem_read},    32'd0);
    check("rw_stall_rst", {31'd0, stall},       32'd0);
    check("rw_pc",    pc_out,                   32'd0);
    check("rw_rd",    {27'd0, rd_address_out},  32'd0);
    check("rw_valid", {31'd0, valid_out},       32'd0);
    @(posedge clk); #1;
    reset = 0;
    clear_inputs();
    pc_ctr = pc_ctr + 4; rd_ctr = rd_ctr + 1;
    @(posedge clk); #1;
    run_op("lw_after_rst", 1, 0, 2'b10, 0, 32'h104, 0, 32'hCAFE_F00D, 0,
           1, 0, 4'b0000, 0, 0, 4'd0, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
